// File: rtl/fir_sequencer.sv
// Sequencer for a 16-tap, 4-group FIR datapath: weight/sample valid-ready streams in, result stream out.
// Define FIR_SEQ_WDOG_EN to enable the WAIT-state watchdog and its sticky wdog_err flag.
module fir_sequencer #(
    parameter int NTAPS  = 16,
    parameter int GROUPS = 4
`ifdef FIR_SEQ_WDOG_EN
    ,
    parameter int TIMEOUT = 32
`endif
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        w_valid,
    input  logic [15:0] w_data,
    output logic        w_ready,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        res_valid,
    output logic [15:0] res_data,
    input  logic        res_ready,
    output logic        fir_wind,
    output logic        fir_load,
    output logic [15:0] fir_data,
    output logic        fir_in_valid,
    input  logic        fir_out_valid,
    input  logic [15:0] fir_out,
    output logic        busy,
    output logic        wdog_err
);

    localparam int WCNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int FILL_W = $clog2(NTAPS + 1);
    localparam int GCNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [2:0] {IDLE, WLOAD, DLOAD, RUN, WAIT, OUT} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic              fir_wind_q, fir_wind_d;
    logic              fir_load_q, fir_load_d;
    logic [15:0]       fir_data_q, fir_data_d;
    logic              fir_in_valid_q, fir_in_valid_d;
    logic              res_valid_q, res_valid_d;
    logic [15:0]       res_data_q, res_data_d;

`ifdef FIR_SEQ_WDOG_EN
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        fill_cnt_d     = fill_cnt_q;
        gcnt_d         = gcnt_q;
        fir_wind_d     = 1'b0;
        fir_load_d     = 1'b0;
        fir_data_d     = fir_data_q;
        fir_in_valid_d = 1'b0;
        res_valid_d    = res_valid_q;
        res_data_d     = res_data_q;
`ifdef FIR_SEQ_WDOG_EN
        wdog_cnt_d     = '0;
        wdog_err_d     = wdog_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (w_valid) begin
                    state_d = WLOAD;
                end else if (s_valid) begin
                    fir_data_d = s_data;
                    fir_load_d = 1'b1;
                    state_d    = DLOAD;
                end
            end
            WLOAD: begin
                if (w_valid) begin
                    fir_data_d = w_data;
                    fir_wind_d = 1'b1;
                    if (wcnt_q == WCNT_W'(NTAPS - 1)) begin
                        wcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            DLOAD: begin
                if (fill_cnt_q != FILL_W'(NTAPS)) begin
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                end
                if (fill_cnt_d == FILL_W'(NTAPS)) begin
                    // First group starts the cycle right after the fir_load cycle.
                    fir_in_valid_d = 1'b1;
                    gcnt_d         = '0;
                    state_d        = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (gcnt_q == GCNT_W'(GROUPS - 1)) begin
                    gcnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    gcnt_d         = gcnt_q + GCNT_W'(1);
                    fir_in_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (fir_out_valid) begin
                    res_data_d  = fir_out;
                    res_valid_d = 1'b1;
                    state_d     = OUT;
                end
`ifdef FIR_SEQ_WDOG_EN
                else if (wdog_cnt_q == WDOG_W'(TIMEOUT - 1)) begin
                    wdog_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
                end
`endif
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rstb) begin
            state_q        <= IDLE;
            wcnt_q         <= '0;
            fill_cnt_q     <= '0;
            gcnt_q         <= '0;
            fir_wind_q     <= 1'b0;
            fir_load_q     <= 1'b0;
            fir_data_q     <= '0;
            fir_in_valid_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
`ifdef FIR_SEQ_WDOG_EN
            wdog_cnt_q     <= '0;
            wdog_err_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            fill_cnt_q     <= fill_cnt_d;
            gcnt_q         <= gcnt_d;
            fir_wind_q     <= fir_wind_d;
            fir_load_q     <= fir_load_d;
            fir_data_q     <= fir_data_d;
            fir_in_valid_q <= fir_in_valid_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
`ifdef FIR_SEQ_WDOG_EN
            wdog_cnt_q     <= wdog_cnt_d;
            wdog_err_q     <= wdog_err_d;
`endif
        end
    end

    // s_ready is gated by rstb so the stream stays closed while reset is held.
    assign s_ready      = rstb && (state_q == IDLE) && !w_valid;
    assign w_ready      = (state_q == WLOAD);
    assign busy         = (state_q != IDLE);
    assign fir_wind     = fir_wind_q;
    assign fir_load     = fir_load_q;
    assign fir_data     = fir_data_q;
    assign fir_in_valid = fir_in_valid_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
`ifdef FIR_SEQ_WDOG_EN
    assign wdog_err     = wdog_err_q;
`else
    assign wdog_err     = 1'b0;
`endif

endmodule
